// File: rtl/pipe_pkg.sv
// Shared pipeline types: ID/EX hazard FSM encoding and the control bundle
// carried from decode through EX into the EX/MEM stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // A non-instruction must never write state downstream.
  function automatic ctrl_t mask_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: a load in EX whose non-zero destination
// is read by the instruction in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  assign load_use = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs) | (ex_rd == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional load-use bubble counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic [3:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rdata_a,
  input  logic [DATA_W-1:0] id_rdata_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic [3:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rdata_a,
  output logic [DATA_W-1:0] ex_rdata_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              stall_o,
  output logic              ex_bubble
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, id_ctrl;
  logic   load_use;

  assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, memtoreg: id_memtoreg,
                     alusrc: id_alusrc, aluop: id_aluop};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ctrl_q.memread),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  assign stall_o = hold_i | (load_use & ~flush_i);

  // Flush wins over hold, hold wins over a load-use bubble.
  always_comb begin
    state_d = ST_RUN;
    if (hold_i && !flush_i) begin
      state_d = ST_HOLD;
    end else if (load_use && !flush_i) begin
      state_d = ST_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign ex_bubble = (state_q == ST_BUBBLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rdata_a <= '0;
      ex_rdata_b <= '0;
      ex_imm     <= '0;
    end else if (flush_i || state_d == ST_BUBBLE) begin
      ex_valid   <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rdata_a <= '0;
      ex_rdata_b <= '0;
      ex_imm     <= '0;
    end else if (state_d == ST_RUN) begin
      ex_valid   <= id_valid;
      ctrl_q     <= mask_ctrl(id_ctrl, id_valid);
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rdata_a <= id_rdata_a;
      ex_rdata_b <= id_rdata_b;
      ex_imm     <= id_imm;
    end
  end

  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_aluop    = ctrl_q.aluop;

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state_d == ST_BUBBLE && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a cycle-level reference model of the
// ID/EX register and its hazard rules; stall_cnt checked when ID_EX_STALL_CNT_EN is set.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        regwrite, memread, memwrite, memtoreg, alusrc;
    logic [3:0]  aluop;
    logic [31:0] a, b, imm;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic hold_i = 1'b0;
  slot_t cur = '0;

  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_rdata_a, ex_rdata_b, ex_imm;
  logic        stall_o, ex_bubble;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.valid), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .id_regwrite(cur.regwrite), .id_memread(cur.memread), .id_memwrite(cur.memwrite),
    .id_memtoreg(cur.memtoreg), .id_alusrc(cur.alusrc), .id_aluop(cur.aluop),
    .id_rdata_a(cur.a), .id_rdata_b(cur.b), .id_imm(cur.imm),
    .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rdata_a(ex_rdata_a), .ex_rdata_b(ex_rdata_b), .ex_imm(ex_imm),
    .stall_o(stall_o), .ex_bubble(ex_bubble)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: what EX must hold, whether it is a bubble, bubble count.
  slot_t       m_ex;
  logic        m_bubble;
  logic [31:0] m_cnt;

  function automatic logic model_hazard(input slot_t ex, input slot_t id);
    return ex.valid && ex.memread && ex.rd != 5'd0 && id.valid &&
           (ex.rd == id.rs || ex.rd == id.rt);
  endfunction

  function automatic slot_t admitted(input slot_t id);
    slot_t s = id;
    if (!id.valid) begin
      s.regwrite = 1'b0; s.memread = 1'b0; s.memwrite = 1'b0;
      s.memtoreg = 1'b0; s.alusrc = 1'b0; s.aluop = 4'd0;
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex <= '0; m_bubble <= 1'b0; m_cnt <= 32'd0;
    end else if (flush_i) begin
      m_ex <= '0; m_bubble <= 1'b0;
    end else if (hold_i) begin
      m_bubble <= 1'b0;
    end else if (model_hazard(m_ex, cur)) begin
      m_ex <= '0; m_bubble <= 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
    end else begin
      m_ex <= admitted(cur); m_bubble <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
    checkOutput("ex_rs", 32'(ex_rs), 32'(m_ex.rs));
    checkOutput("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
    checkOutput("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    checkOutput("ex_ctrl",
                32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop}),
                32'({m_ex.regwrite, m_ex.memread, m_ex.memwrite, m_ex.memtoreg, m_ex.alusrc, m_ex.aluop}));
    checkOutput("ex_rdata_a", ex_rdata_a, m_ex.a);
    checkOutput("ex_rdata_b", ex_rdata_b, m_ex.b);
    checkOutput("ex_imm", ex_imm, m_ex.imm);
    checkOutput("ex_bubble", 32'(ex_bubble), 32'(m_bubble));
    checkOutput("stall_o", 32'(stall_o),
                32'(hold_i | (model_hazard(m_ex, cur) & ~flush_i)));
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, m_cnt);
`endif
  end

  function automatic slot_t mk(input logic v, input logic [4:0] rs, rt, rd,
                               input logic rw, mr, m2r, input logic [3:0] op,
                               input logic [31:0] a, imm);
    slot_t s = '0;
    s.valid = v; s.rs = rs; s.rt = rt; s.rd = rd;
    s.regwrite = rw; s.memread = mr; s.memtoreg = m2r; s.alusrc = mr;
    s.aluop = op; s.a = a; s.b = a ^ 32'h5555_0000; s.imm = imm;
    return s;
  endfunction

  task automatic applyStimulus(input slot_t v, input logic fl, input logic ho);
    cur = v; flush_i = fl; hold_i = ho;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic checkCnt(input string name, input logic [31:0] exp);
`ifdef ID_EX_STALL_CNT_EN
    checkOutput(name, stall_cnt, exp);
`else
    if (exp == 32'hFFFF_FFFF) $display("[TB] counter not built");
`endif
  endtask

  initial begin
    slot_t plain, load7, use7, use77, load0, use0;
    plain = mk(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 4'h1, 32'h11, 32'h0);
    load7 = mk(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 4'h2, 32'h100, 32'h8);
    use7  = mk(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 4'h3, 32'hAA, 32'h0);
    use77 = mk(1'b1, 5'd7, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0, 4'h4, 32'hBB, 32'h0);
    load0 = mk(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 4'h2, 32'h200, 32'h4);
    use0  = mk(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 4'h5, 32'hCC, 32'h0);

    // Outputs must be zero while reset is held.
    #12;
    checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset ex_bubble", 32'(ex_bubble), 32'd0);
    checkOutput("reset stall_o", 32'(stall_o), 32'd0);
    checkCnt("reset stall_cnt", 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    $display("[TB] plain capture");
    applyStimulus(plain, 1'b0, 1'b0); tick();
    checkOutput("cap ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("cap ex_rd", 32'(ex_rd), 32'd5);
    checkOutput("cap ex_rdata_a", ex_rdata_a, 32'h11);
    checkOutput("cap stall_o", 32'(stall_o), 32'd0);

    $display("[TB] invalid instruction masks control");
    applyStimulus(mk(1'b0, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 4'hF, 32'h1, 32'h2), 1'b0, 1'b0);
    tick();
    checkOutput("inv ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("inv ex_regwrite", 32'(ex_regwrite), 32'd0);
    checkOutput("inv ex_memread", 32'(ex_memread), 32'd0);
    checkOutput("inv ex_rd", 32'(ex_rd), 32'd6);

    $display("[TB] load-use");
    applyStimulus(load7, 1'b0, 1'b0); tick();
    applyStimulus(use7, 1'b0, 1'b0); #1;
    checkOutput("lu stall_o", 32'(stall_o), 32'd1);
    tick();
    checkOutput("lu bubble ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu ex_bubble", 32'(ex_bubble), 32'd1);
    checkOutput("lu bubble stall_o", 32'(stall_o), 32'd0);
    checkCnt("lu stall_cnt", 32'd1);
    tick();
    checkOutput("lu after ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("lu after ex_rd", 32'(ex_rd), 32'd9);
    checkOutput("lu after ex_rdata_a", ex_rdata_a, 32'hAA);
    checkOutput("lu after ex_bubble", 32'(ex_bubble), 32'd0);

    $display("[TB] rs == rt == load rd stalls once");
    applyStimulus(load7, 1'b0, 1'b0); tick();
    applyStimulus(use77, 1'b0, 1'b0); tick();
    checkOutput("dup ex_bubble", 32'(ex_bubble), 32'd1);
    tick();
    checkOutput("dup after ex_rd", 32'(ex_rd), 32'd10);
    checkOutput("dup after ex_bubble", 32'(ex_bubble), 32'd0);
    checkCnt("dup stall_cnt", 32'd2);

    $display("[TB] load to r0");
    applyStimulus(load0, 1'b0, 1'b0); tick();
    applyStimulus(use0, 1'b0, 1'b0); #1;
    checkOutput("r0 stall_o", 32'(stall_o), 32'd0);
    tick();
    checkOutput("r0 ex_bubble", 32'(ex_bubble), 32'd0);
    checkOutput("r0 ex_rd", 32'(ex_rd), 32'd11);

    $display("[TB] flush with hold and load-use");
    applyStimulus(load7, 1'b0, 1'b0); tick();
    applyStimulus(use7, 1'b1, 1'b1); #1;
    checkOutput("fl stall_o", 32'(stall_o), 32'd1);
    tick();
    checkOutput("fl ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("fl ex_bubble", 32'(ex_bubble), 32'd0);
    checkCnt("fl stall_cnt", 32'd2);

    $display("[TB] hold");
    applyStimulus(plain, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1'b1, 5'(12 + i), 5'd13, 5'(20 + i), 1'b1, 1'b0, 1'b0, 4'h6,
                       32'(i), 32'h0), 1'b0, 1'b1);
      #1;
      checkOutput("hold stall_o", 32'(stall_o), 32'd1);
      tick();
      checkOutput("hold ex_rd", 32'(ex_rd), 32'd5);
      checkOutput("hold ex_rdata_a", ex_rdata_a, 32'h11);
    end
    applyStimulus(mk(1'b1, 5'd14, 5'd15, 5'd12, 1'b1, 1'b0, 1'b0, 4'h7, 32'h77, 32'h0),
                  1'b0, 1'b0);
    tick();
    checkOutput("resume ex_rd", 32'(ex_rd), 32'd12);
    checkOutput("resume ex_rdata_a", ex_rdata_a, 32'h77);

    $display("[TB] async reset mid-bubble");
    applyStimulus(load7, 1'b0, 1'b0); tick();
    applyStimulus(use7, 1'b0, 1'b0); tick();
    checkOutput("pre-reset ex_bubble", 32'(ex_bubble), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst ex_bubble", 32'(ex_bubble), 32'd0);
    checkOutput("arst ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("arst ex_rd", 32'(ex_rd), 32'd0);
    checkOutput("arst stall_o", 32'(stall_o), 32'd0);
    checkCnt("arst stall_cnt", 32'd0);
    #3 rst_n = 1'b1;
    applyStimulus(plain, 1'b0, 1'b0); tick();
    checkOutput("post-reset ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("post-reset ex_bubble", 32'(ex_bubble), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
